pe_array_ctrl_seq: RTL and testbench

//  Parametrised per-layer sequencer that generates the full PE-array control set (line/filter shift,
//  MAC, adder, NL, feedback enables) for an N_PE x N_PE array from a layer descriptor.

---
 rtl/pe_array_ctrl_seq.sv | 189 ++++++++++++++++++
 tb/tb_pe_array_ctrl_seq.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_array_ctrl_seq.sv
// pe_array_ctrl_seq: per-layer sequencer driving the shift/MAC/adder/NL/feedback enables of an N_PE x N_PE array
// Optional feature: define PE_CTRL_STRIDE2_EN to add cfg_stride2 (MAC only on even row/col offsets from K-1).
// Ports:
//   clk, rst (async, active high), start, cfg_row_length (W), cfg_num_rows (H), cfg_kernel (K),
//   cfg_num_banks (B, 0 means 1), cfg_nl_type, cfg_pool_en, in_valid / in_ready input handshake,
//   busy, done, cfg_err, line_buffer_reset, shifting_line / shifting_filter / mac_enable (flattened r*N_PE+c),
//   adder_enable / nl_enable / feedback_enable (per row), final_filter_bank, nl_type, pool_enable.
// Every output is a flop; shift/MAC enables appear the cycle after the accepted beat.
module pe_array_ctrl_seq #(
    parameter int N_PE   = 8,
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 12,
    parameter int BANK_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ADDR_W-1:0]      cfg_row_length,
    input  logic [CNT_W-1:0]       cfg_num_rows,
    input  logic [2:0]             cfg_kernel,
    input  logic [BANK_W-1:0]      cfg_num_banks,
    input  logic [2:0]             cfg_nl_type,
    input  logic                   cfg_pool_en,
`ifdef PE_CTRL_STRIDE2_EN
    input  logic                   cfg_stride2,
`endif
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   busy,
    output logic                   done,
    output logic                   cfg_err,
    output logic                   line_buffer_reset,
    output logic [N_PE*N_PE-1:0]   shifting_line,
    output logic [N_PE*N_PE-1:0]   shifting_filter,
    output logic [N_PE*N_PE-1:0]   mac_enable,
    output logic [N_PE-1:0]        adder_enable,
    output logic [N_PE-1:0]        nl_enable,
    output logic [N_PE-1:0]        feedback_enable,
    output logic                   final_filter_bank,
    output logic [2:0]             nl_type,
    output logic                   pool_enable
);
    typedef enum logic [2:0] {IDLE, FLUSH, LOAD_FILT, PRIME, STREAM, DRAIN, DONE} state_t;
    state_t state, state_n;
    logic [ADDR_W-1:0] w_last, col, col_n;
    logic [CNT_W-1:0] h_last, row, row_n;
    logic [2:0] k, k_m1, k_m2, fcnt, fcnt_n;
    logic [BANK_W-1:0] b_last, b_last_n, bank, bank_n;
    logic drain_cnt, drain_n, legal, accept, beat, mac_beat, mac_q, stride_ok;
    logic [N_PE*N_PE-1:0] a_mask;
    logic [N_PE-1:0] r_mask;
`ifdef PE_CTRL_STRIDE2_EN
    logic stride2;
    // (col-(K-1)) and (row-(K-1)) even is a parity match against K-1
    assign stride_ok = !stride2 || (col[0] == k_m1[0] && row[0] == k_m1[0]);
`else
    assign stride_ok = 1'b1;
`endif
    assign k_m1 = k - 3'd1;
    assign k_m2 = k - 3'd2;
    assign legal = cfg_kernel != 3'd0 && 32'(cfg_kernel) <= N_PE &&
                   cfg_num_rows >= CNT_W'(cfg_kernel) && cfg_row_length >= ADDR_W'(cfg_kernel);
    assign accept = state == IDLE && start && legal;
    assign beat = in_valid && in_ready;
    assign mac_beat = beat && state == STREAM && col >= ADDR_W'(k_m1) && stride_ok;
    assign b_last_n = accept ? ((cfg_num_banks == '0) ? '0 : cfg_num_banks - BANK_W'(1)) : b_last;
    always_comb begin
        a_mask = '0;
        r_mask = '0;
        for (int r = 0; r < N_PE; r++) begin
            r_mask[r] = r < int'(k);
            for (int c = 0; c < N_PE; c++)
                a_mask[r*N_PE+c] = r < int'(k) && c < int'(k);
        end
    end
    always_comb begin
        state_n = state;
        fcnt_n = fcnt;
        col_n = col;
        row_n = row;
        bank_n = bank;
        drain_n = drain_cnt;
        case (state)
            IDLE: begin
                state_n = accept ? FLUSH : IDLE;
                bank_n = accept ? '0 : bank;
            end
            FLUSH: begin
                state_n = LOAD_FILT;
                fcnt_n = '0;
            end
            LOAD_FILT: if (beat) begin
                fcnt_n = fcnt + 3'd1;
                if (fcnt == k_m1) begin
                    // K==1 has no priming window
                    state_n = (k == 3'd1) ? STREAM : PRIME;
                    col_n = '0;
                    row_n = '0;
                end
            end
            PRIME, STREAM: if (beat) begin
                col_n = (col == w_last) ? '0 : col + ADDR_W'(1);
                row_n = (col == w_last) ? row + CNT_W'(1) : row;
                // last priming beat sits at (K-1, K-2); last stream beat at (H-1, W-1)
                if (state == PRIME && row == CNT_W'(k_m1) && col == ADDR_W'(k_m2))
                    state_n = STREAM;
                if (state == STREAM && row == h_last && col == w_last) begin
                    state_n = DRAIN;
                    drain_n = 1'b0;
                end
            end
            DRAIN: begin
                drain_n = 1'b1;
                state_n = drain_cnt ? ((bank == b_last) ? DONE : FLUSH) : DRAIN;
                bank_n = (drain_cnt && bank != b_last) ? bank + BANK_W'(1) : bank;
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            fcnt <= '0;
            col <= '0;
            row <= '0;
            bank <= '0;
            drain_cnt <= 1'b0;
            k <= '0;
            w_last <= '0;
            h_last <= '0;
            b_last <= '0;
`ifdef PE_CTRL_STRIDE2_EN
            stride2 <= 1'b0;
`endif
        end else begin
            state <= state_n;
            fcnt <= fcnt_n;
            col <= col_n;
            row <= row_n;
            bank <= bank_n;
            drain_cnt <= drain_n;
            b_last <= b_last_n;
            if (accept) begin
                k <= cfg_kernel;
                w_last <= cfg_row_length - ADDR_W'(1);
                h_last <= cfg_num_rows - CNT_W'(1);
`ifdef PE_CTRL_STRIDE2_EN
                stride2 <= cfg_stride2;
`endif
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            cfg_err <= 1'b0;
            line_buffer_reset <= 1'b0;
            shifting_line <= '0;
            shifting_filter <= '0;
            mac_enable <= '0;
            mac_q <= 1'b0;
            adder_enable <= '0;
            nl_enable <= '0;
            feedback_enable <= '0;
            final_filter_bank <= 1'b0;
            nl_type <= '0;
            pool_enable <= 1'b0;
        end else begin
            in_ready <= state_n inside {LOAD_FILT, PRIME, STREAM};
            busy <= state_n != IDLE;
            done <= state_n == DONE;
            cfg_err <= state == IDLE && start && !legal;
            line_buffer_reset <= state_n == FLUSH;
            shifting_filter <= (beat && state == LOAD_FILT) ? a_mask : '0;
            shifting_line <= (beat && (state == PRIME || state == STREAM)) ? a_mask : '0;
            mac_enable <= mac_beat ? a_mask : '0;
            mac_q <= mac_beat;
            adder_enable <= mac_q ? r_mask : '0;
            nl_enable <= adder_enable;
            feedback_enable <= (state_n inside {STREAM, DRAIN} && bank_n != '0) ? r_mask : '0;
            final_filter_bank <= state_n != IDLE && bank_n == b_last_n;
            nl_type <= accept ? cfg_nl_type : nl_type;
            pool_enable <= accept ? cfg_pool_en : pool_enable;
        end
    end
endmodule

// File: tb/tb_pe_array_ctrl_seq.sv
// tb_pe_array_ctrl_seq: randomized self-checking bench against a beat-list reference model
module tb_pe_array_ctrl_seq;
    localparam int NP = 4;
    logic clk = 0, rst = 1, start = 0, in_valid = 0, cfg_pool_en = 0;
    logic [9:0] cfg_row_length = 0;
    logic [11:0] cfg_num_rows = 0;
    logic [2:0] cfg_kernel = 0, cfg_nl_type = 0;
    logic [7:0] cfg_num_banks = 0;
`ifdef PE_CTRL_STRIDE2_EN
    logic cfg_stride2 = 0;
`endif
    logic in_ready, busy, done, cfg_err, line_buffer_reset, final_filter_bank, pool_enable;
    logic [NP*NP-1:0] shifting_line, shifting_filter, mac_enable;
    logic [NP-1:0] adder_enable, nl_enable, feedback_enable;
    logic [2:0] nl_type;
    int ncmp = 0, nfail = 0;
    logic [NP*NP-1:0] last_mac;

    typedef struct {int kind; bit mac; int bank;} item_t;

    pe_array_ctrl_seq #(.N_PE(NP), .ADDR_W(10), .CNT_W(12), .BANK_W(8)) dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_row_length(cfg_row_length), .cfg_num_rows(cfg_num_rows), .cfg_kernel(cfg_kernel),
        .cfg_num_banks(cfg_num_banks), .cfg_nl_type(cfg_nl_type), .cfg_pool_en(cfg_pool_en),
`ifdef PE_CTRL_STRIDE2_EN
        .cfg_stride2(cfg_stride2),
`endif
        .in_valid(in_valid), .in_ready(in_ready), .busy(busy), .done(done), .cfg_err(cfg_err),
        .line_buffer_reset(line_buffer_reset), .shifting_line(shifting_line),
        .shifting_filter(shifting_filter), .mac_enable(mac_enable), .adder_enable(adder_enable),
        .nl_enable(nl_enable), .feedback_enable(feedback_enable),
        .final_filter_bank(final_filter_bank), .nl_type(nl_type), .pool_enable(pool_enable)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic zero_chk(input string tag);
        chk({tag, ".in_ready"}, in_ready, 0);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".done"}, done, 0);
        chk({tag, ".cfg_err"}, cfg_err, 0);
        chk({tag, ".lbr"}, line_buffer_reset, 0);
        chk({tag, ".sh_line"}, shifting_line, 0);
        chk({tag, ".sh_filt"}, shifting_filter, 0);
        chk({tag, ".mac"}, mac_enable, 0);
        chk({tag, ".adder"}, adder_enable, 0);
        chk({tag, ".nl"}, nl_enable, 0);
        chk({tag, ".feedback"}, feedback_enable, 0);
        chk({tag, ".final"}, final_filter_bank, 0);
        chk({tag, ".nl_type"}, nl_type, 0);
        chk({tag, ".pool"}, pool_enable, 0);
    endtask

    function automatic logic [NP*NP-1:0] amask(input int k);
        amask = '0;
        for (int r = 0; r < k; r++)
            for (int c = 0; c < k; c++) amask[r*NP+c] = 1'b1;
    endfunction

    function automatic logic [NP-1:0] rmask(input int k);
        rmask = '0;
        for (int r = 0; r < k; r++) rmask[r] = 1'b1;
    endfunction

    // Reference: the layer is a list of cycles/beats; kinds 0 FLUSH, 1 filter beat, 2 prime beat,
    // 3 stream beat, 4 drain cycle, 5 done cycle, 6 idle cycle.
    task automatic run_layer(input int k, input int w, input int h, input int b, input int vmode,
                             input int st, input int nlt, input int pool);
        item_t q[$];
        item_t it;
        int beff, p, cyc, macs, flushes, dones, exp_macs;
        logic [NP*NP-1:0] am;
        logic [NP-1:0] rm;
        bit e_sf, e_sl, e_mac, e_add, e_nl;
        beff = (b == 0) ? 1 : b;
        p = (k - 1) * w + (k - 1);
        am = amask(k);
        rm = rmask(k);
        for (int bk = 0; bk < beff; bk++) begin
            q.push_back('{0, 0, bk});
            repeat (k) q.push_back('{1, 0, bk});
            for (int i = 0; i < h * w; i++) begin
                int r, c;
                bit m;
                r = i / w;
                c = i % w;
                m = i >= p && c >= k - 1 && (st == 0 || ((c - (k - 1)) % 2 == 0 && (r - (k - 1)) % 2 == 0));
                q.push_back('{(i < p) ? 2 : 3, m, bk});
            end
            q.push_back('{4, 0, bk});
            q.push_back('{4, 0, bk});
        end
        q.push_back('{5, 0, beff - 1});
        repeat (3) q.push_back('{6, 0, 0});
        exp_macs = st != 0 ? beff * ((h - k + 2) / 2) * ((w - k + 2) / 2) : beff * (h - k + 1) * (w - k + 1);
        @(negedge clk);
        cfg_kernel = 3'(k);
        cfg_row_length = 10'(w);
        cfg_num_rows = 12'(h);
        cfg_num_banks = 8'(b);
        cfg_nl_type = 3'(nlt);
        cfg_pool_en = pool[0];
`ifdef PE_CTRL_STRIDE2_EN
        cfg_stride2 = st[0];
`endif
        start = 1;
        in_valid = vmode != 1;
        {e_sf, e_sl, e_mac, e_add, e_nl} = '0;
        cyc = 0;
        macs = 0;
        flushes = 0;
        dones = 0;
        while (q.size() > 0 && cyc < 8000) begin
            @(negedge clk);
            cyc++;
            it = q[0];
            chk("in_ready", in_ready, it.kind inside {1, 2, 3});
            chk("busy", busy, it.kind != 6);
            chk("lbr", line_buffer_reset, it.kind == 0);
            chk("done", done, it.kind == 5);
            chk("cfg_err", cfg_err, 0);
            chk("feedback", feedback_enable, (it.kind inside {3, 4} && it.bank > 0) ? rm : '0);
            chk("final_bank", final_filter_bank, it.kind != 6 && it.bank == beff - 1);
            chk("sh_filt", shifting_filter, e_sf ? am : '0);
            chk("sh_line", shifting_line, e_sl ? am : '0);
            chk("mac", mac_enable, e_mac ? am : '0);
            chk("adder", adder_enable, e_add ? rm : '0);
            chk("nl", nl_enable, e_nl ? rm : '0);
            chk("nl_type", nl_type, nlt);
            chk("pool", pool_enable, pool);
            if (mac_enable != '0) begin
                macs++;
                last_mac = mac_enable;
            end
            flushes += int'(line_buffer_reset);
            dones += int'(done);
            // scramble config and poke start while busy: both must be ignored
            start = it.kind != 6 && $urandom_range(0, 3) == 0;
            cfg_kernel = 3'($urandom);
            cfg_row_length = 10'($urandom_range(0, 9));
            cfg_num_rows = 12'($urandom_range(0, 9));
            cfg_num_banks = 8'($urandom);
            cfg_nl_type = 3'($urandom);
            cfg_pool_en = 1'($urandom);
`ifdef PE_CTRL_STRIDE2_EN
            cfg_stride2 = 1'($urandom);
`endif
            in_valid = vmode == 0 ? 1'b1 : vmode == 1 ? ~in_valid : ($urandom_range(0, 3) != 0);
            e_nl = e_add;
            e_add = e_mac;
            {e_sf, e_sl, e_mac} = '0;
            if (!(it.kind inside {1, 2, 3}) || in_valid) begin
                void'(q.pop_front());
                e_sf = it.kind == 1;
                e_sl = it.kind inside {2, 3};
                e_mac = it.mac;
            end
        end
        start = 0;
        chk("timeout", q.size(), 0);
        chk("mac_count", macs, exp_macs);
        chk("flush_count", flushes, beff);
        chk("done_count", dones, 1);
    endtask

    task automatic bad_cfg(input int k, input int w, input int h);
        @(negedge clk);
        cfg_kernel = 3'(k);
        cfg_row_length = 10'(w);
        cfg_num_rows = 12'(h);
        cfg_num_banks = 8'd1;
        start = 1;
        in_valid = 1;
        @(negedge clk);
        start = 0;
        chk("bad.cfg_err", cfg_err, 1);
        chk("bad.busy", busy, 0);
        chk("bad.lbr", line_buffer_reset, 0);
        repeat (2) begin
            @(negedge clk);
            chk("bad.cfg_err_clear", cfg_err, 0);
            chk("bad.busy_idle", busy, 0);
            chk("bad.in_ready", in_ready, 0);
            chk("bad.sh_line", shifting_line, 0);
            chk("bad.mac", mac_enable, 0);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        zero_chk("reset");
        rst = 0;
        @(negedge clk);
        zero_chk("post_reset");

        run_layer(3, 5, 4, 1, 0, 0, 5, 1);
        run_layer(3, 5, 4, 1, 1, 0, 2, 0);
        run_layer(2, 4, 3, 3, 2, 0, 7, 1);
        run_layer(4, 4, 5, 1, 2, 0, 1, 0);
        chk("full_mask", last_mac, 16'hFFFF);
        run_layer(1, 3, 2, 0, 2, 0, 3, 1);

        bad_cfg(0, 5, 5);
        bad_cfg(NP + 1, 6, 6);
        bad_cfg(3, 5, 2);
        bad_cfg(3, 2, 5);

        // abort in the middle of STREAM: K=3,W=5,H=4 streams in cycles 17..24
        @(negedge clk);
        cfg_kernel = 3;
        cfg_row_length = 5;
        cfg_num_rows = 4;
        cfg_num_banks = 1;
        cfg_nl_type = 6;
        cfg_pool_en = 1;
        start = 1;
        in_valid = 1;
        @(negedge clk);
        start = 0;
        repeat (19) @(negedge clk);
        chk("abort.in_stream", in_ready, 1);
        chk("abort.sh_line", shifting_line, amask(3));
        rst = 1;
        #1;
        zero_chk("abort_async");
        @(posedge clk);
        #1;
        zero_chk("abort_edge");
        @(negedge clk);
        rst = 0;
        in_valid = 0;
        @(negedge clk);
        zero_chk("abort_idle");
        run_layer(3, 5, 4, 1, 2, 0, 4, 0);

        for (int i = 0; i < 6; i++) begin
            int k, w, h;
            k = $urandom_range(1, NP);
            w = $urandom_range(k, 6);
            h = $urandom_range(k, 5);
            run_layer(k, w, h, $urandom_range(0, 2), 2, 0, $urandom_range(0, 7), $urandom_range(0, 1));
        end
`ifdef PE_CTRL_STRIDE2_EN
        run_layer(3, 7, 7, 1, 0, 1, 2, 1);
        run_layer(2, 6, 5, 2, 2, 1, 5, 0);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
